// File: rtl/iterative_multiplier_if.sv
// Register-file facing bus of the iterative multiplier: request side
// (start, operands, destination) and write-back side (busy, write port).
interface iterative_multiplier_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
);
  logic              start;
  logic              op_high;
  logic [WIDTH-1:0]  operand_a;
  logic [WIDTH-1:0]  operand_b;
  logic [ADDR_W-1:0] dest_addr;
  logic              busy;
  logic [WIDTH-1:0]  write_data;
  logic [ADDR_W-1:0] write_addr;
  logic              write_enable;

  // Issuing side: drives requests, observes busy and the write port.
  modport master (
    output start, op_high, operand_a, operand_b, dest_addr,
    input  busy, write_data, write_addr, write_enable
  );

  // Multiplier side: accepts requests, drives busy and the write port.
  modport slave (
    input  start, op_high, operand_a, operand_b, dest_addr,
    output busy, write_data, write_addr, write_enable
  );
endinterface

// File: rtl/iterative_multiplier.sv
// Shift-and-add unsigned multiplier, one multiplier bit per clock.
// A request is captured in IDLE, WIDTH iterations run in RUN, and the
// selected half of the 2*WIDTH-bit product is written back in DONE.
module iterative_multiplier #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input logic                  clk,
  input logic                  rst,
  iterative_multiplier_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic               r_op_high;
  logic [ADDR_W-1:0]  r_dest;
  logic               r_busy;
  logic               r_we;
  logic [WIDTH-1:0]   r_wdata;
  logic [ADDR_W-1:0]  r_waddr;

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_last;

  // Picks the half of the full product requested by the instruction.
  function automatic logic [WIDTH-1:0] select_half(
    input logic [2*WIDTH-1:0] prod,
    input logic               hi
  );
    select_half = hi ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
  endfunction

  // Conditional add into the upper half with carry kept, then the whole
  // {carry, accumulator} shifts right so no product bit is ever lost.
  always_comb begin
    w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
              + {1'b0, (r_mplr[0] ? r_mcand : {WIDTH{1'b0}})};
    w_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
    w_last    = (r_cnt == CNT_W'(WIDTH - 1));
  end

  // Control FSM plus datapath registers; every output comes from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_op_high <= 1'b0;
      r_dest    <= '0;
      r_busy    <= 1'b0;
      r_we      <= 1'b0;
      r_wdata   <= '0;
      r_waddr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mcand   <= bus.operand_a;
            r_mplr    <= bus.operand_b;
            r_op_high <= bus.op_high;
            r_dest    <= bus.dest_addr;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc  <= w_acc_nxt;
          r_mplr <= r_mplr >> 1;
          r_cnt  <= r_cnt + CNT_W'(1);
          // Last iteration: w_acc_nxt is the finished product, so the
          // write port is loaded on the same edge that enters DONE.
          if (w_last) begin
            r_wdata <= select_half(w_acc_nxt, r_op_high);
            r_waddr <= r_dest;
            r_we    <= (r_dest != '0);
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_we    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.write_data   = r_wdata;
  assign bus.write_addr   = r_waddr;
  assign bus.write_enable = r_we;

endmodule

// File: doc/iterative_multiplier.md
ITERATIVE_MULTIPLIER -- requirements
Module: iterative_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand and result width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 3, register-address width.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-006 The block SHALL have port op_high  input  1  0 = return low WIDTH bits of product, 1 = return high WIDTH bits.
REQ-007 The block SHALL have port operand_a  input  WIDTH  multiplicand, driven from register-file read port 0.
REQ-008 The block SHALL have port operand_b  input  WIDTH  multiplier, driven from register-file read port 1.
REQ-009 The block SHALL have port dest_addr  input  ADDR_W  destination register for the result.
REQ-010 The block SHALL have port busy  output  1  high while an operation is in progress; upstream stalls on it.
REQ-011 The block SHALL have port write_data  output  WIDTH  result, to register-file write data.
REQ-012 The block SHALL have port write_addr  output  ADDR_W  captured dest_addr, to register-file write address.
REQ-013 The block SHALL have port write_enable  output  1  one-cycle write strobe to register file.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, RUN, DONE; all outputs registered.
REQ-015 In IDLE with start=1 at a rising edge, the block SHALL capture operand_a, operand_b, op_high, dest_addr, clear a 2*WIDTH-bit product accumulator and iteration counter, and enter RUN.
REQ-016 In RUN, each edge SHALL: if the current multiplier LSB is 1, add the multiplicand to the upper WIDTH bits of the accumulator with a WIDTH+1-bit sum (carry kept), then shift {carry, accumulator} right by one and consume one multiplier bit; counter increments.
REQ-017 After exactly WIDTH RUN edges, the block SHALL enter DONE; product is the unsigned 2*WIDTH-bit operand_a*operand_b, no overflow or truncation before selection.
REQ-018 In DONE, write_data SHALL equal product[2*WIDTH-1:WIDTH] if captured op_high=1, else product[WIDTH-1:0]; write_addr SHALL equal captured dest_addr.
REQ-019 write_enable SHALL be high for exactly the one DONE cycle, i.e. WIDTH+1 cycles after the start edge, then the FSM SHALL return to IDLE on the next edge.
REQ-020 If captured dest_addr is 0, write_enable SHALL stay low in DONE (r0 is hard-wired zero); latency and busy unchanged.
REQ-021 busy SHALL be high in RUN and DONE, low in IDLE; busy rises in the cycle after the accepted start edge.
REQ-022 start asserted in RUN or DONE SHALL be ignored entirely; no queueing; changes on operand/dest inputs after capture SHALL not affect the result.
REQ-023 Back-to-back: start high in the IDLE cycle immediately following DONE SHALL be accepted normally.
REQ-024 write_data and write_addr SHALL hold their last values outside DONE; only write_enable qualifies them.

Reset
REQ-025 rst=1 SHALL immediately, independent of clk, force state IDLE, busy=0, write_enable=0, write_data=0, write_addr=0, counter and accumulator 0.
REQ-026 rst asserted mid-operation (RUN or DONE) SHALL abort it with no write_enable pulse, including a pending DONE.
REQ-027 After rst deasserts, the first start SHALL be accepted at the first rising edge where start=1.

Verification
REQ-028 a=13, b=11, op_high=0, dest=3, start one cycle -> busy for 9 cycles; write_enable one cycle 9 cycles after start edge, write_data=0x8F, write_addr=3.
REQ-029 a=0xFF, b=0xFF, op_high=1, dest=5 -> write_data=0xFE; repeat with op_high=0 -> write_data=0x01.
REQ-030 a=0x00, b=0xA5, dest=2 -> write_data=0x00 with write_enable pulse; then a=0x80, b=0x02, op_high=1 -> write_data=0x01.
REQ-031 Start accepted, then start=1 with new operands held during RUN/DONE -> only one write_enable, result of first operands; new op accepted only in next IDLE.
REQ-032 dest=0, a=7, b=9 -> busy for 9 cycles, write_enable never asserted.
REQ-033 rst pulsed 4 cycles after start -> busy=0, all outputs 0 asynchronously, no write_enable; new start after release yields correct result on schedule.
